// File: rtl/peripheral_mpi_pkg.sv
// Shared encodings for the AHB3-Lite MPI mailbox: register offsets, AHB codes, STATUS layout.
package peripheral_mpi_pkg;

    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;
    localparam logic [2:0] HsizeWord    = 3'b010;
    localparam logic       HrespOkay    = 1'b0;
    localparam logic       HrespError   = 1'b1;

    localparam logic [7:0] OffTxData     = 8'h00;
    localparam logic [7:0] OffTxLast     = 8'h04;
    localparam logic [7:0] OffTxChan     = 8'h08;
    localparam logic [7:0] OffStatus     = 8'h0C;
    localparam logic [7:0] OffIrqEn      = 8'h10;
    localparam logic [7:0] OffRxDataBase = 8'h40;
    localparam logic [7:0] OffRxStatBase = 8'h80;

    localparam int unsigned StatTxFull     = 0;
    localparam int unsigned StatTxEmpty    = 1;
    localparam int unsigned StatUnderflow  = 2;
    localparam int unsigned StatTxCountLsb = 8;

    typedef enum logic [1:0] {StOkay, StErr1, StErr2} err_state_e;

    typedef enum logic [2:0] {
        RegNone, RegTxData, RegTxLast, RegTxChan, RegStatus, RegIrqEn, RegRxData, RegRxStat
    } reg_e;

endpackage

// File: rtl/peripheral_mpi_fifo.sv
// Synchronous FIFO with combinational head output; push is refused when full, pop when empty.
module peripheral_mpi_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(DEPTH);
    localparam logic [PtrW:0]   CntOne  = 1;
    localparam logic [PtrW-1:0] PtrOne  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FullCnt);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntOne;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/peripheral_mpi_mbox_ahb3.sv
// AHB3-Lite MPI message endpoint: TX FIFO onto a flit stream, per-channel RX FIFOs with interrupts.
module peripheral_mpi_mbox_ahb3
    import peripheral_mpi_pkg::*;
#(
    parameter int unsigned HADDR_SIZE = 8,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned ChanW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [HDATA_SIZE-1:0] tx_data_o,
    output logic                  tx_last_o,
    output logic [ChanW-1:0]      tx_chan_o,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    input  logic [HDATA_SIZE-1:0] rx_data_i,
    input  logic                  rx_last_i,
    input  logic [ChanW-1:0]      rx_chan_i,
    output logic [CHANNELS-1:0]   event_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TxW  = HDATA_SIZE + 1 + ChanW;
    localparam int unsigned RxW  = HDATA_SIZE + 1;
    localparam logic [3:0]  NumCh   = 4'(CHANNELS);
    localparam logic [CntW:0] TxLimit = (CntW + 1)'(FIFO_DEPTH);

    err_state_e state_q, state_d;
    reg_e       reg_sel, wr_reg_q;
    logic       wr_pend_q;
    logic [HDATA_SIZE-1:0] hrdata_q, hrdata_d, rd_val;
    logic [ChanW-1:0]      txchan_q, txchan_d;
    logic [CHANNELS-1:0]   irq_en_q, irq_en_d;
    logic                  underflow_q, underflow_d, underflow_set;

    logic [7:0] off;
    logic [3:0] ch_sel;
    logic       accept, addr_err, acc_ok, acc_err, pend_tx, tx_full_eff;
    logic [CntW:0] tx_used;

    logic            tx_push, tx_pop, tx_full, tx_empty;
    logic [TxW-1:0]  tx_wdata, tx_rdata;
    logic [CntW-1:0] tx_count;

    logic [CHANNELS-1:0] rx_push, rx_pop, rx_full, rx_empty;
    logic [RxW-1:0]      rx_rdata [CHANNELS];
    logic [CntW-1:0]     rx_count [CHANNELS];

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HADDR};

    assign off    = HADDR[7:0];
    assign ch_sel = off[5:2];

    always_comb begin
        reg_sel = RegNone;
        if (off[1:0] == 2'b00) begin
            if (off == OffTxData)                                   reg_sel = RegTxData;
            else if (off == OffTxLast)                              reg_sel = RegTxLast;
            else if (off == OffTxChan)                              reg_sel = RegTxChan;
            else if (off == OffStatus)                              reg_sel = RegStatus;
            else if (off == OffIrqEn)                               reg_sel = RegIrqEn;
            else if (off[7:6] == OffRxDataBase[7:6] && ch_sel < NumCh) reg_sel = RegRxData;
            else if (off[7:6] == OffRxStatBase[7:6] && ch_sel < NumCh) reg_sel = RegRxStat;
        end
    end

    // A TX write still in its data phase has not reached the FIFO yet but already owns a slot.
    assign pend_tx     = wr_pend_q & ((wr_reg_q == RegTxData) | (wr_reg_q == RegTxLast));
    assign tx_used     = {1'b0, tx_count} + {{CntW{1'b0}}, pend_tx};
    assign tx_full_eff = (tx_used >= TxLimit);

    assign accept = HSEL & HREADY & ((HTRANS == HtransNonseq) | (HTRANS == HtransSeq))
                  & (state_q != StErr1);
    assign addr_err = (reg_sel == RegNone) | (HSIZE != HsizeWord)
                    | (HWRITE & ((reg_sel == RegRxData) | (reg_sel == RegRxStat)))
                    | (!HWRITE & ((reg_sel == RegTxData) | (reg_sel == RegTxLast)))
                    | (HWRITE & ((reg_sel == RegTxData) | (reg_sel == RegTxLast)) & tx_full_eff);
    assign acc_ok  = accept & ~addr_err;
    assign acc_err = accept & addr_err;

    // Reads resolve in the address phase so data and RX pops land on the same edge.
    always_comb begin
        rd_val        = '0;
        rx_pop        = '0;
        underflow_set = 1'b0;
        if (acc_ok && !HWRITE) begin
            case (reg_sel)
                RegTxChan: rd_val[ChanW-1:0] = txchan_q;
                RegStatus: begin
                    rd_val[StatTxFull]                          = tx_full;
                    rd_val[StatTxEmpty]                         = tx_empty;
                    rd_val[StatUnderflow]                       = underflow_q;
                    rd_val[StatTxCountLsb+7:StatTxCountLsb]     = 8'(tx_count);
                end
                RegIrqEn: rd_val[CHANNELS-1:0] = irq_en_q;
                RegRxData: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (ch_sel == 4'(c)) begin
                            if (rx_empty[c]) begin
                                underflow_set = 1'b1;
                            end else begin
                                rd_val    = rx_rdata[c][HDATA_SIZE-1:0];
                                rx_pop[c] = 1'b1;
                            end
                        end
                    end
                end
                RegRxStat: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (ch_sel == 4'(c)) begin
                            rd_val[7:0] = 8'(rx_count[c]);
                            rd_val[8]   = rx_rdata[c][HDATA_SIZE] & ~rx_empty[c];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Writes commit at the edge closing their data phase, when HWDATA is valid.
    always_comb begin
        hrdata_d    = accept ? rd_val : hrdata_q;
        txchan_d    = txchan_q;
        irq_en_d    = irq_en_q;
        underflow_d = underflow_q | underflow_set;
        if (wr_pend_q) begin
            case (wr_reg_q)
                RegTxChan: txchan_d = HWDATA[ChanW-1:0];
                RegIrqEn:  irq_en_d = HWDATA[CHANNELS-1:0];
                RegStatus: if (HWDATA[StatUnderflow] && !underflow_set) underflow_d = 1'b0;
                default: ;
            endcase
        end
    end

    assign tx_push  = pend_tx;
    assign tx_wdata = {txchan_q, (wr_reg_q == RegTxLast), HWDATA};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hrdata_q    <= '0;
            wr_pend_q   <= 1'b0;
            wr_reg_q    <= RegNone;
            txchan_q    <= '0;
            irq_en_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            hrdata_q    <= hrdata_d;
            wr_pend_q   <= acc_ok & HWRITE;
            wr_reg_q    <= reg_sel;
            txchan_q    <= txchan_d;
            irq_en_q    <= irq_en_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= StOkay;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StOkay:  if (acc_err) state_d = StErr1;
            StErr1:  state_d = StErr2;
            StErr2:  state_d = acc_err ? StErr1 : StOkay;
            default: state_d = StOkay;
        endcase
    end

    always_comb begin
        HREADYOUT = (state_q != StErr1);
        HRESP     = (state_q == StOkay) ? HrespOkay : HrespError;
        HRDATA    = hrdata_q;
    end

    peripheral_mpi_fifo #(.WIDTH(TxW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (tx_push),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign tx_valid_o = ~tx_empty;
    assign tx_pop     = tx_valid_o & tx_ready_i;
    assign {tx_chan_o, tx_last_o, tx_data_o} = tx_rdata;

    // Out-of-range channels see rx_ready_o=1 with no push, so their words are dropped.
    always_comb begin
        rx_ready_o = 1'b1;
        rx_push    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rx_chan_i == ChanW'(c)) begin
                rx_ready_o = ~rx_full[c];
                rx_push[c] = rx_valid_i & ~rx_full[c];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_rx
        peripheral_mpi_fifo #(.WIDTH(RxW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
            .clk   (HCLK),
            .rst_n (HRESETn),
            .push  (rx_push[g]),
            .wdata ({rx_last_i, rx_data_i}),
            .pop   (rx_pop[g]),
            .rdata (rx_rdata[g]),
            .full  (rx_full[g]),
            .empty (rx_empty[g]),
            .count (rx_count[g])
        );
    end

    assign event_o = irq_en_q & ~rx_empty;

endmodule

// File: tb/tb_peripheral_mpi_mbox_ahb3.sv
// Directed self-checking bench for the AHB3-Lite MPI mailbox (4 channels, depth 8).
module tb_peripheral_mpi_mbox_ahb3;

    logic        clk, hresetn, hsel, hwrite, hmastlock, hreadyout, hresp;
    logic [7:0]  haddr;
    logic [31:0] hwdata, hrdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    wire         hready;
    logic        tx_valid, tx_ready, tx_last, rx_valid, rx_ready, rx_last;
    logic [31:0] tx_data, rx_data;
    logic [1:0]  tx_chan, rx_chan;
    logic [3:0]  evt;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd;
    logic [1:0]  c1, c2;
    logic [34:0] flits[$];

    assign hready = hreadyout;

    peripheral_mpi_mbox_ahb3 dut (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(hready), .HRDATA(hrdata), .HREADYOUT(hreadyout),
        .HRESP(hresp), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
        .tx_last_o(tx_last), .tx_chan_o(tx_chan), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .rx_data_i(rx_data), .rx_last_i(rx_last), .rx_chan_i(rx_chan), .event_o(evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (tx_valid && tx_ready) flits.push_back({tx_chan, tx_last, tx_data});

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One non-pipelined transfer; c1/c2 are {HREADYOUT,HRESP} in the two cycles after the address edge.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size, input logic [1:0] trans,
                        output logic [31:0] rdata, output logic [1:0] r1, output logic [1:0] r2);
        hsel = 1'b1; haddr = addr; hwrite = wr; hsize = size; htrans = trans;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
        rdata = hrdata; r1 = {hreadyout, hresp};
        @(posedge clk); #1;
        r2 = {hreadyout, hresp};
    endtask

    task automatic rx_send(input logic [1:0] ch, input logic [31:0] d, input logic l);
        rx_valid = 1'b1; rx_chan = ch; rx_data = d; rx_last = l;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain_tx();
        int k;
        k = 0;
        tx_ready = 1'b1;
        while (tx_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_tx: tx_valid=%b required 0", tx_valid); end
    endtask

    task automatic test_reset();
        checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h required 0", hrdata); end
        checks++; if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL reset_resp: got %b required 10", {hreadyout, hresp}); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b required 1", rx_ready); end
        checks++; if (evt !== 4'h0) begin errors++; $display("FAIL reset_event: got %b required 0000", evt); end
        xfer(1'b0, 8'h0C, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL reset_status: got %h required 00000002", rd); end
        checks++; if (c1 !== 2'b10) begin errors++; $display("FAIL reset_status_resp: got %b required 10", c1); end
        xfer(1'b0, 8'h10, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_irq_en: got %h required 0", rd); end
    endtask

    task automatic test_tx();
        flits.delete();
        tx_ready = 1'b1;
        xfer(1'b1, 8'h08, 32'h2, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_valid_before: got %b required 0", tx_valid); end
        xfer(1'b1, 8'h00, 32'hA5A5_0001, 3'b010, 2'b10, rd, c1, c2);
        checks++; if ({tx_valid, tx_chan, tx_last, tx_data} !== {1'b1, 2'd2, 1'b0, 32'hA5A5_0001}) begin
            errors++; $display("FAIL tx_first_flit: got v=%b ch=%0d l=%b d=%h required v=1 ch=2 l=0 d=a5a50001",
                               tx_valid, tx_chan, tx_last, tx_data); end
        xfer(1'b1, 8'h04, 32'hA5A5_0002, 3'b010, 2'b10, rd, c1, c2);
        repeat (3) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        checks++; if (flits.size() !== 2) begin errors++; $display("FAIL tx_flit_count: got %0d required 2", flits.size()); end
        if (flits.size() == 2) begin
            checks++; if (flits[0] !== {2'd2, 1'b0, 32'hA5A5_0001}) begin errors++; $display("FAIL tx_flit0: got %h required %h", flits[0], {2'd2, 1'b0, 32'hA5A5_0001}); end
            checks++; if (flits[1] !== {2'd2, 1'b1, 32'hA5A5_0002}) begin errors++; $display("FAIL tx_flit1: got %h required %h", flits[1], {2'd2, 1'b1, 32'hA5A5_0002}); end
        end
    endtask

    task automatic test_tx_overflow();
        logic bad;
        flits.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            xfer(1'b1, 8'h00, 32'(i), 3'b010, 2'b10, rd, c1, c2);
            if (i < 8) begin
                checks++; if (c1 !== 2'b10) begin errors++; $display("FAIL ovf_write%0d_resp: got %b required 10", i, c1); end
            end else begin
                checks++; if ({c1, c2} !== 4'b0111) begin errors++; $display("FAIL ovf_error_resp: got %b,%b required 01,11", c1, c2); end
            end
        end
        xfer(1'b0, 8'h0C, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h0000_0801) begin errors++; $display("FAIL ovf_status: got %h required 00000801", rd); end
        drain_tx();
        bad = (flits.size() != 8);
        for (int i = 0; i < flits.size() && i < 8; i++) if (flits[i] !== {2'd2, 1'b0, 32'(i)}) bad = 1'b1;
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL ovf_drained_flits: %0d flits, contents ok=%b, required 8 in order", flits.size(), !bad); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) xfer(1'b1, 8'h00, 32'h10 + 32'(i), 3'b010, 2'b10, rd, c1, c2);
        hsel = 1'b1; haddr = 8'h00; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
        @(posedge clk); #1;
        hwdata = 32'h100;
        checks++; if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL b2b_first_resp: got %b required 10", {hreadyout, hresp}); end
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        checks++; if ({hreadyout, hresp} !== 2'b01) begin errors++; $display("FAIL b2b_err1: got %b required 01", {hreadyout, hresp}); end
        @(posedge clk); #1;
        checks++; if ({hreadyout, hresp} !== 2'b11) begin errors++; $display("FAIL b2b_err2: got %b required 11", {hreadyout, hresp}); end
        @(posedge clk); #1;
        xfer(1'b0, 8'h0C, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h0000_0801) begin errors++; $display("FAIL b2b_status: got %h required 00000801", rd); end
        drain_tx();
    endtask

    task automatic test_rx();
        xfer(1'b1, 8'h10, 32'h2, 3'b010, 2'b10, rd, c1, c2);
        rx_send(2'd1, 32'h1111_1111, 1'b0);
        rx_send(2'd1, 32'h2222_2222, 1'b0);
        rx_send(2'd1, 32'h3333_3333, 1'b1);
        checks++; if (evt !== 4'b0010) begin errors++; $display("FAIL rx_event_on: got %b required 0010", evt); end
        xfer(1'b0, 8'h84, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL rx_stat_3: got %h required 00000003", rd); end
        xfer(1'b0, 8'h44, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL rx_pop1: got %h required 11111111", rd); end
        xfer(1'b0, 8'h44, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h2222_2222) begin errors++; $display("FAIL rx_pop2: got %h required 22222222", rd); end
        checks++; if (evt !== 4'b0010) begin errors++; $display("FAIL rx_event_hold: got %b required 0010", evt); end
        xfer(1'b0, 8'h84, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h101) begin errors++; $display("FAIL rx_stat_last: got %h required 00000101", rd); end
        xfer(1'b0, 8'h44, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h3333_3333) begin errors++; $display("FAIL rx_pop3: got %h required 33333333", rd); end
        checks++; if (evt !== 4'b0000) begin errors++; $display("FAIL rx_event_off: got %b required 0000", evt); end
    endtask

    task automatic test_underflow();
        xfer(1'b0, 8'h40, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if ({c1, rd} !== {2'b10, 32'h0}) begin errors++; $display("FAIL uf_read: got resp %b data %h required 10 / 0", c1, rd); end
        xfer(1'b0, 8'h0C, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h6) begin errors++; $display("FAIL uf_status_set: got %h required 00000006", rd); end
        xfer(1'b1, 8'h0C, 32'h4, 3'b010, 2'b10, rd, c1, c2);
        xfer(1'b0, 8'h0C, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL uf_status_clear: got %h required 00000002", rd); end
    endtask

    task automatic test_rx_full();
        for (int i = 0; i < 8; i++) rx_send(2'd3, 32'h300 + 32'(i), 1'b0);
        rx_chan = 2'd3; #1;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL full_ready_ch3: got %b required 0", rx_ready); end
        rx_chan = 2'd0; #1;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL full_ready_ch0: got %b required 1", rx_ready); end
        hsel = 1'b1; haddr = 8'h4C; hwrite = 1'b0; hsize = 3'b010; htrans = 2'b10;
        rx_valid = 1'b1; rx_chan = 2'd3; rx_data = 32'hDEAD; rx_last = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; rx_valid = 1'b0;
        checks++; if (hrdata !== 32'h300) begin errors++; $display("FAIL full_pop_data: got %h required 00000300", hrdata); end
        @(posedge clk); #1;
        xfer(1'b0, 8'h8C, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h7) begin errors++; $display("FAIL full_count_after: got %h required 00000007", rd); end
    endtask

    task automatic test_errors();
        xfer(1'b0, 8'h20, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if ({c1, c2} !== 4'b0111) begin errors++; $display("FAIL err_unmapped: got %b,%b required 01,11", c1, c2); end
        xfer(1'b0, 8'h0C, 32'h0, 3'b001, 2'b10, rd, c1, c2);
        checks++; if ({c1, c2} !== 4'b0111) begin errors++; $display("FAIL err_hsize: got %b,%b required 01,11", c1, c2); end
        xfer(1'b1, 8'h80, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if ({c1, c2} !== 4'b0111) begin errors++; $display("FAIL err_write_ro: got %b,%b required 01,11", c1, c2); end
        xfer(1'b0, 8'h04, 32'h0, 3'b010, 2'b11, rd, c1, c2);
        checks++; if ({c1, c2} !== 4'b0111) begin errors++; $display("FAIL err_read_txlast: got %b,%b required 01,11", c1, c2); end
        xfer(1'b0, 8'h50, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if ({c1, c2} !== 4'b0111) begin errors++; $display("FAIL err_rx_chan4: got %b,%b required 01,11", c1, c2); end
        xfer(1'b1, 8'h08, 32'h1, 3'b000, 2'b10, rd, c1, c2);
        xfer(1'b1, 8'h08, 32'h3, 3'b010, 2'b01, rd, c1, c2);
        checks++; if ({c1, c2} !== 4'b1010) begin errors++; $display("FAIL busy_okay: got %b,%b required 10,10", c1, c2); end
        xfer(1'b1, 8'h08, 32'h0, 3'b010, 2'b00, rd, c1, c2);
        xfer(1'b0, 8'h08, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL err_no_side_effect: TXCHAN got %h required 00000002", rd); end
    endtask

    task automatic test_reset_mid();
        rx_send(2'd2, 32'hAB, 1'b0);
        xfer(1'b1, 8'h00, 32'hCAFE, 3'b010, 2'b10, rd, c1, c2);
        #2 hresetn = 1'b0;
        #1;
        checks++; if ({tx_valid, rx_ready} !== 2'b01) begin errors++; $display("FAIL rst_async: got tx_valid=%b rx_ready=%b required 0/1", tx_valid, rx_ready); end
        @(posedge clk); #1 hresetn = 1'b1;
        xfer(1'b0, 8'h88, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_rxstat2: got %h required 0", rd); end
        xfer(1'b0, 8'h8C, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_rxstat3: got %h required 0", rd); end
        xfer(1'b0, 8'h08, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_txchan: got %h required 0", rd); end
        xfer(1'b0, 8'h0C, 32'h0, 3'b010, 2'b10, rd, c1, c2);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL rst_status: got %h required 00000002", rd); end
    endtask

    initial begin
        hresetn = 1'b0; hsel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = 3'b010;
        hburst = '0; hprot = '0; htrans = '0; hmastlock = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_last = 1'b0; rx_chan = '0;
        repeat (3) @(posedge clk);
        #1 hresetn = 1'b1;
        test_reset();
        test_tx();
        test_tx_overflow();
        test_back_to_back();
        test_rx();
        test_underflow();
        test_rx_full();
        test_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
